// File: rtl/haar_stage_evaluator.sv
// Weak-classifier stage evaluator: selects a leaf per feature, accumulates the stage sum
// and compares it with the stage threshold. HAAR_STAGE_SATURATE_EN enables saturating adds.
module haar_stage_evaluator #(
    parameter int unsigned FEAT_W = 16,
    parameter int unsigned LEAF_W = 12,
    parameter int unsigned ACC_W  = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rst_local,
    input  logic                     feature_valid,
    input  logic signed [FEAT_W-1:0] feature_value,
    input  logic signed [FEAT_W-1:0] feature_threshold,
    input  logic signed [LEAF_W-1:0] left_val,
    input  logic signed [LEAF_W-1:0] right_val,
    input  logic                     last_feature,
    input  logic signed [ACC_W-1:0]  stage_threshold,
    output logic                     stage_status,
    output logic                     stage_done,
    output logic signed [ACC_W-1:0]  stage_sum,
    output logic                     proto_err
);

    typedef enum logic [1:0] {StIdle, StAccum, StDecide, StDone} state_e;

    state_e                   state_q;
    logic                     s1_valid_q, s1_last_q;
    logic signed [FEAT_W-1:0] s1_value_q, s1_thr_q;
    logic signed [LEAF_W-1:0] s1_left_q, s1_right_q;
    logic                     s2_valid_q, s2_last_q;
    logic signed [LEAF_W-1:0] s2_leaf_q;
    logic signed [ACC_W-1:0]  stage_thr_q, acc_q;
    logic                     status_q, done_q, err_q, last_seen_q;

    logic                     accept, feature_err, sat_event;
    logic signed [LEAF_W-1:0] leaf_sel;
    logic signed [ACC_W-1:0]  leaf_ext, sum_next;

    // Once the last feature is in flight, further features belong to no stage.
    assign accept = feature_valid && !rst_local && !last_seen_q &&
                    (state_q == StIdle || state_q == StAccum);
    assign feature_err = feature_valid && !rst_local && !accept;

    assign leaf_sel = (s1_value_q < s1_thr_q) ? s1_left_q : s1_right_q;
    assign leaf_ext = ACC_W'(s2_leaf_q);

`ifdef HAAR_STAGE_SATURATE_EN
    logic [ACC_W:0] sum_wide;
    logic           ovf;

    always_comb begin
        sum_wide  = {acc_q[ACC_W-1], acc_q} + {leaf_ext[ACC_W-1], leaf_ext};
        ovf       = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        sat_event = s2_valid_q && ovf;
        if (!ovf) begin
            sum_next = sum_wide[ACC_W-1:0];
        end else if (sum_wide[ACC_W]) begin
            sum_next = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            sum_next = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign sum_next  = acc_q + leaf_ext;
    assign sat_event = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_value_q  <= '0;
            s1_thr_q    <= '0;
            s1_left_q   <= '0;
            s1_right_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_leaf_q   <= '0;
            stage_thr_q <= '0;
            acc_q       <= '0;
            status_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            last_seen_q <= 1'b0;
        end else if (rst_local) begin
            // stage_status survives: the control unit samples it during rst_local.
            state_q     <= StIdle;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            acc_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            last_seen_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            s1_valid_q <= accept;
            if (accept) begin
                s1_last_q  <= last_feature;
                s1_value_q <= feature_value;
                s1_thr_q   <= feature_threshold;
                s1_left_q  <= left_val;
                s1_right_q <= right_val;
                if (last_feature) begin
                    last_seen_q <= 1'b1;
                    stage_thr_q <= stage_threshold;
                end
            end
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s2_leaf_q  <= leaf_sel;
            if (s2_valid_q) begin
                acc_q <= sum_next;
            end
            if (feature_err || sat_event) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    if (s2_valid_q && s2_last_q) begin
                        state_q <= StDecide;
                    end
                end
                StDecide: begin
                    status_q <= (acc_q >= stage_thr_q);
                    done_q   <= 1'b1;
                    state_q  <= StDone;
                end
                StDone: begin
                    state_q <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stage_status = status_q;
    assign stage_done   = done_q;
    assign stage_sum    = acc_q;
    assign proto_err    = err_q;

endmodule

// File: tb/tb_haar_stage_evaluator.sv
// Directed bench for haar_stage_evaluator: table of single-feature stages plus
// hand-written multi-feature, rst_local, protocol-error and narrow-accumulator sequences.
module tb_haar_stage_evaluator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_local = 1'b0;
    logic feature_valid = 1'b0;
    logic signed [15:0] feature_value = '0, feature_threshold = '0;
    logic signed [11:0] left_val = '0, right_val = '0;
    logic last_feature = 1'b0;
    logic signed [19:0] stage_threshold = '0;
    logic stage_status, stage_done, proto_err;
    logic signed [19:0] stage_sum;

    // Narrow instance for overflow behaviour
    logic fv8 = 1'b0, last8 = 1'b0;
    logic signed [7:0] zero8 = '0, sthr8 = '0;
    logic signed [5:0] left8 = '0, right8 = 6'sd10;
    logic status8, done8, err8;
    logic signed [7:0] sum8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    haar_stage_evaluator dut (
        .clk(clk), .rst_n(rst_n), .rst_local(rst_local), .feature_valid(feature_valid),
        .feature_value(feature_value), .feature_threshold(feature_threshold),
        .left_val(left_val), .right_val(right_val), .last_feature(last_feature),
        .stage_threshold(stage_threshold), .stage_status(stage_status),
        .stage_done(stage_done), .stage_sum(stage_sum), .proto_err(proto_err)
    );

    haar_stage_evaluator #(.FEAT_W(8), .LEAF_W(6), .ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .rst_local(1'b0), .feature_valid(fv8),
        .feature_value(zero8), .feature_threshold(zero8),
        .left_val(left8), .right_val(right8), .last_feature(last8),
        .stage_threshold(sthr8), .stage_status(status8),
        .stage_done(done8), .stage_sum(sum8), .proto_err(err8)
    );

    typedef struct {
        logic signed [15:0] fv;
        logic signed [15:0] ft;
        logic signed [11:0] lv;
        logic signed [11:0] rv;
        logic signed [19:0] sthr;
        logic signed [19:0] sum;
        logic               st;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_feat(input logic signed [15:0] v, input logic signed [15:0] t,
                              input logic signed [11:0] l, input logic signed [11:0] r,
                              input logic lst, input logic signed [19:0] sthr);
        feature_value = v;
        feature_threshold = t;
        left_val = l;
        right_val = r;
        last_feature = lst;
        stage_threshold = sthr;
        feature_valid = 1'b1;
        tick();
        feature_valid = 1'b0;
        last_feature = 1'b0;
    endtask

    // Called right after the edge that sampled the last feature.
    task automatic expect_decision(input string name, input logic signed [19:0] sum,
                                   input logic st);
        tick();
        tick();
        check({name, " done_early"}, stage_done, 0);
        tick();
        check({name, " done_pulse"}, stage_done, 1);
        check({name, " sum"}, stage_sum, sum);
        check({name, " status"}, stage_status, st);
        tick();
        check({name, " done_single"}, stage_done, 0);
    endtask

    task automatic clear_stage();
        rst_local = 1'b1;
        tick();
        rst_local = 1'b0;
    endtask

    initial begin
        bit saw_done;
        vecs[0] = '{16'sd100, 16'sd100, -12'sd5, 12'sd5, 20'sd0, 20'sd5, 1'b1};
        vecs[1] = '{16'sd32767, 16'sh8000, 12'sd2047, 12'sh800, -20'sd2048, -20'sd2048, 1'b1};
        vecs[2] = '{16'sh8000, 16'sd32767, 12'sd2047, 12'sh800, 20'sd2048, 20'sd2047, 1'b0};
        vecs[3] = '{-16'sd1, 16'sd0, -12'sd5, 12'sd5, 20'sd0, -20'sd5, 1'b0};
        vecs[4] = '{-16'sd1, 16'sd0, -12'sd5, 12'sd5, -20'sd5, -20'sd5, 1'b1};

        tick();
        tick();
        check("reset status", stage_status, 0);
        check("reset done", stage_done, 0);
        check("reset sum", stage_sum, 0);
        check("reset err", proto_err, 0);
        rst_n = 1'b1;
        tick();

        // Three features: 7 + 7 - 4 = 10
        drive_feat(16'sd10, 16'sd0, -12'sd4, 12'sd7, 1'b0, 20'sd0);
        drive_feat(16'sd5, 16'sd0, -12'sd4, 12'sd7, 1'b0, 20'sd0);
        drive_feat(-16'sd3, 16'sd0, -12'sd4, 12'sd7, 1'b1, 20'sd14);
        expect_decision("three_thr14", 20'sd10, 1'b0);
        clear_stage();
        check("clear sum", stage_sum, 0);

        drive_feat(16'sd10, 16'sd0, -12'sd4, 12'sd7, 1'b0, 20'sd0);
        drive_feat(16'sd5, 16'sd0, -12'sd4, 12'sd7, 1'b0, 20'sd0);
        drive_feat(-16'sd3, 16'sd0, -12'sd4, 12'sd7, 1'b1, 20'sd10);
        expect_decision("three_thr10", 20'sd10, 1'b1);
        clear_stage();

        for (int i = 0; i < 5; i++) begin
            drive_feat(vecs[i].fv, vecs[i].ft, vecs[i].lv, vecs[i].rv, 1'b1, vecs[i].sthr);
            expect_decision($sformatf("vec%0d", i), vecs[i].sum, vecs[i].st);
            clear_stage();
        end

        // rst_local with the second feature: stage abandoned, status (1) retained
        drive_feat(16'sd10, 16'sd0, -12'sd4, 12'sd7, 1'b0, 20'sd0);
        rst_local = 1'b1;
        drive_feat(16'sd5, 16'sd0, -12'sd4, 12'sd7, 1'b0, 20'sd0);
        rst_local = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (stage_done) saw_done = 1'b1;
        end
        check("abort no_done", saw_done, 0);
        check("abort sum", stage_sum, 0);
        check("abort status", stage_status, 1);

        // Feature while in DONE
        drive_feat(16'sd100, 16'sd100, -12'sd5, 12'sd5, 1'b1, 20'sd0);
        expect_decision("pre_done", 20'sd5, 1'b1);
        check("done err_before", proto_err, 0);
        drive_feat(16'sd1, 16'sd0, -12'sd5, 12'sd7, 1'b1, 20'sd0);
        tick();
        tick();
        check("done err_set", proto_err, 1);
        check("done sum_hold", stage_sum, 5);
        clear_stage();
        check("done err_clear", proto_err, 0);
        check("done status_keep", stage_status, 1);

        // Reset deasserting mid-stage loses the partial sum
        drive_feat(16'sd10, 16'sd0, -12'sd4, 12'sd7, 1'b0, 20'sd0);
        drive_feat(16'sd10, 16'sd0, -12'sd4, 12'sd7, 1'b0, 20'sd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (stage_done) saw_done = 1'b1;
        end
        check("rstn no_done", saw_done, 0);
        check("rstn sum", stage_sum, 0);

        // 20 x right=10 into an 8-bit accumulator
        for (int i = 0; i < 20; i++) begin
            fv8 = 1'b1;
            last8 = (i == 19);
            tick();
        end
        fv8 = 1'b0;
        last8 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
`ifdef HAAR_STAGE_SATURATE_EN
        check("acc8 sum", sum8, 127);
        check("acc8 err", err8, 1);
        check("acc8 status", status8, 1);
`else
        check("acc8 sum", sum8, -56);
        check("acc8 err", err8, 0);
        check("acc8 status", status8, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
